// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate build and illegal-encoding detection,
// registered behind a 2-entry skid buffer with valid/ready on both sides and flush.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      fn3,
  output logic            fn7_5,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      fn3;
    logic            fn7_5;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t      state, state_nxt;
  entry_t      dec, out_q, skid_q;
  logic [2:0]  f;
  logic [31:0] imm32;
  logic        in_xfer, out_xfer;
  logic        ld_out_dec, ld_out_skid, ld_skid;
  logic        in_ready_q;

  // Every listed opcode ends in 2'b11, so a bad instr[1:0] falls through to NONE.
  always_comb begin
    f = FMT_NONE;
    case (in_instr[6:0])
      7'b0110011: f = (in_instr[31:25] == 7'b0000000 || in_instr[31:25] == 7'b0100000) ? FMT_R : FMT_NONE;
      7'b0010011,
      7'b0000011: f = FMT_I;
      7'b1100111: f = (in_instr[14:12] == 3'b000) ? FMT_I : FMT_NONE;
      7'b0100011: f = FMT_S;
      7'b1100011: f = FMT_B;
      7'b0110111,
      7'b0010111: f = FMT_U;
      7'b1101111: f = FMT_J;
      default:    f = FMT_NONE;
    endcase
  end

  always_comb begin
    imm32       = '0;
    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = in_instr[6:0];
    dec.fmt     = f;
    dec.illegal = (f == FMT_NONE);
    case (f)
      FMT_R: begin
        dec.rd    = in_instr[11:7];
        dec.rs1   = in_instr[19:15];
        dec.rs2   = in_instr[24:20];
        dec.fn3   = in_instr[14:12];
        dec.fn7_5 = in_instr[30];
      end
      FMT_I: begin
        dec.rd    = in_instr[11:7];
        dec.rs1   = in_instr[19:15];
        dec.fn3   = in_instr[14:12];
        // slli/srli/srai carry the arithmetic-shift select in instr[30]
        dec.fn7_5 = (in_instr[6:0] == 7'b0010011 && in_instr[13:12] == 2'b01) ? in_instr[30] : 1'b0;
        imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      FMT_S: begin
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.fn3 = in_instr[14:12];
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      FMT_B: begin
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.fn3 = in_instr[14:12];
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      FMT_U: begin
        dec.rd = in_instr[11:7];
        imm32  = {in_instr[31:12], 12'b0};
      end
      FMT_J: begin
        dec.rd = in_instr[11:7];
        imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nxt   = state;
    ld_out_dec  = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state)
      EMPTY: if (in_xfer) begin
        state_nxt  = ONE;
        ld_out_dec = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          ld_out_dec = 1'b1;
        end else if (in_xfer) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        state_nxt   = ONE;
        ld_out_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt   = EMPTY;
      ld_out_dec  = 1'b0;
      ld_out_skid = 1'b0;
      ld_skid     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
      if (ld_out_dec)       out_q <= dec;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= dec;
    end
  end

  assign out_pc  = out_q.pc;
  assign opcode  = out_q.opcode;
  assign rd      = out_q.rd;
  assign rs1     = out_q.rs1;
  assign rs2     = out_q.rs2;
  assign fn3     = out_q.fn3;
  assign fn7_5   = out_q.fn7_5;
  assign imm     = out_q.imm;
  assign fmt     = out_q.fmt;
  assign illegal = out_q.illegal;

endmodule
